// File: rtl/cpu_defs.sv
// Shared definitions for the RISC CPU: opcode values, sequencer state encodings
// and the packed strobe bundle the controller drives.
package cpu_defs;

    localparam int OP_W    = 3;
    localparam int STATE_W = 4;

    localparam logic [OP_W-1:0] HLT = 3'd0;
    localparam logic [OP_W-1:0] SKZ = 3'd1;
    localparam logic [OP_W-1:0] ADD = 3'd2;
    localparam logic [OP_W-1:0] AND = 3'd3;
    localparam logic [OP_W-1:0] XOR = 3'd4;
    localparam logic [OP_W-1:0] LDA = 3'd5;
    localparam logic [OP_W-1:0] STO = 3'd6;
    localparam logic [OP_W-1:0] JMP = 3'd7;

    typedef enum logic [STATE_W-1:0] {
        S0    = 4'd0,
        S1    = 4'd1,
        S2    = 4'd2,
        S3    = 4'd3,
        S4    = 4'd4,
        S5    = 4'd5,
        S6    = 4'd6,
        S7    = 4'd7,
        SHALT = 4'd8
    } state_t;

    typedef struct packed {
        logic halt;
        logic datactl_ena;
        logic wr;
        logic rd;
        logic load_ir;
        logic load_acc;
        logic load_pc;
        logic inc_pc;
    } strobes_t;

endpackage

// File: rtl/cpu_controller_if.sv
// Connection between the instruction sequencer and the datapath: run enable,
// opcode and zero flag in, per-cycle strobes out.
interface cpu_controller_if;
    import cpu_defs::*;

    logic            ena;
    logic [OP_W-1:0] opcode;
    logic            zero;
    logic            inc_pc;
    logic            load_pc;
    logic            load_acc;
    logic            load_ir;
    logic            rd;
    logic            wr;
    logic            datactl_ena;
    logic            halt;

    modport master (
        input  ena, opcode, zero,
        output inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt
    );

    modport slave (
        output ena, opcode, zero,
        input  inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt
    );

endinterface

// File: rtl/cpu_controller.sv
// Eight-cycle instruction sequencer: two-byte fetch, opcode latch, then per-opcode
// strobes. All outputs are registered and decoded from the state being entered.
module cpu_controller
    import cpu_defs::*;
(
    input  logic             clk,
    input  logic             rst,
    cpu_controller_if.master bus
);

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            skip_q, skip_d;
    logic            run_q, run_d;
    strobes_t        out_q, out_d;

    localparam strobes_t FETCH = '{rd: 1'b1, load_ir: 1'b1, inc_pc: 1'b1, default: 1'b0};

    // run_q distinguishes "idle, parked at S0" from "executing S0": the first
    // enabled cycle after reset or idle enters S0 so both fetch pulses are issued.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        skip_d  = skip_q;
        run_d   = run_q;
        out_d   = '0;

        if (state_q == SHALT) begin
            state_d    = SHALT;
            out_d.halt = 1'b1;
        end else if (!bus.ena) begin
            state_d = S0;
            run_d   = 1'b0;
            skip_d  = 1'b0;
        end else if (!run_q) begin
            state_d = S0;
            run_d   = 1'b1;
            out_d   = FETCH;
        end else begin
            case (state_q)
                S0: begin
                    state_d = S1;
                    out_d   = FETCH;
                end
                S1: state_d = S2;
                S2: begin
                    state_d = S3;
                    op_d    = bus.opcode;
                end
                S3: begin
                    if (op_q == HLT) begin
                        state_d    = SHALT;
                        out_d.halt = 1'b1;
                    end else begin
                        state_d = S4;
                        // zero is sampled only here; S5 reuses the stored decision
                        case (op_q)
                            ADD, AND, XOR, LDA: out_d.rd          = 1'b1;
                            STO:                out_d.datactl_ena = 1'b1;
                            JMP:                out_d.load_pc     = 1'b1;
                            SKZ: begin
                                out_d.inc_pc = bus.zero;
                                skip_d       = bus.zero;
                            end
                            default: ;
                        endcase
                    end
                end
                S4: begin
                    state_d = S5;
                    case (op_q)
                        ADD, AND, XOR, LDA: begin
                            out_d.rd       = 1'b1;
                            out_d.load_acc = 1'b1;
                        end
                        STO: begin
                            out_d.datactl_ena = 1'b1;
                            out_d.wr          = 1'b1;
                        end
                        JMP:     out_d.load_pc = 1'b1;
                        SKZ:     out_d.inc_pc  = skip_q;
                        default: ;
                    endcase
                end
                S5: begin
                    state_d           = S6;
                    out_d.datactl_ena = (op_q == STO);
                end
                S6: state_d = S7;
                S7: begin
                    state_d = S0;
                    out_d   = FETCH;
                end
                default: begin
                    state_d = S0;
                    run_d   = 1'b0;
                    skip_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S0;
            op_q    <= '0;
            skip_q  <= 1'b0;
            run_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            skip_q  <= skip_d;
            run_q   <= run_d;
            out_q   <= out_d;
        end
    end

    assign bus.halt        = out_q.halt;
    assign bus.datactl_ena = out_q.datactl_ena;
    assign bus.wr          = out_q.wr;
    assign bus.rd          = out_q.rd;
    assign bus.load_ir     = out_q.load_ir;
    assign bus.load_acc    = out_q.load_acc;
    assign bus.load_pc     = out_q.load_pc;
    assign bus.inc_pc      = out_q.inc_pc;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: a table of full instruction frames plus
// hand-written halt, enable-abort and mid-frame reset sequences.
module tb_cpu_controller;
    import cpu_defs::*;

    // Output vector bit order: {halt, datactl_ena, wr, rd, load_ir, load_acc, load_pc, inc_pc}
    localparam logic [7:0] O_NONE  = 8'h00;
    localparam logic [7:0] O_FETCH = 8'h19;
    localparam logic [7:0] O_RD    = 8'h10;
    localparam logic [7:0] O_RDACC = 8'h14;
    localparam logic [7:0] O_DCTL  = 8'h40;
    localparam logic [7:0] O_DCWR  = 8'h60;
    localparam logic [7:0] O_LDPC  = 8'h02;
    localparam logic [7:0] O_INC   = 8'h01;
    localparam logic [7:0] O_HALT  = 8'h80;

    typedef struct {
        logic [OP_W-1:0] op;
        logic            zero;
        logic [7:0]      exp;
    } vec_t;

    logic clk;
    logic rst;
    cpu_controller_if bus ();

    cpu_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] dut_out;
    assign dut_out = {bus.halt, bus.datactl_ena, bus.wr, bus.rd,
                      bus.load_ir, bus.load_acc, bus.load_pc, bus.inc_pc};

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    int   exp_inc[$];

    // Strobe exclusivity must hold on every cycle, whatever the stimulus
    always @(negedge clk) begin
        n_checks++;
        if ((bus.wr && bus.rd) || (bus.wr && !bus.datactl_ena) || (bus.load_pc && bus.inc_pc)) begin
            n_fail++;
            $display("[TB] FAIL strobe_exclusive at %0t: got %02h, required no wr+rd, no wr without datactl_ena, no load_pc+inc_pc",
                     $time, dut_out);
        end
    end

    task automatic applyStimulus(input logic [OP_W-1:0] op, input logic z);
        bus.opcode = op;
        bus.zero   = z;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp);
        n_checks++;
        if (dut_out !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %02h required %02h", name, dut_out, exp);
        end
    endtask

    task automatic add_frame(input logic [OP_W-1:0] op, input logic z4, input logic z5,
                             input logic [7:0] e4, input logic [7:0] e5, input logic [7:0] e6,
                             input int inc);
        vecs.push_back(vec_t'{op, 1'b0, O_FETCH});
        vecs.push_back(vec_t'{op, 1'b0, O_FETCH});
        vecs.push_back(vec_t'{op, 1'b0, O_NONE});
        vecs.push_back(vec_t'{op, 1'b0, O_NONE});
        vecs.push_back(vec_t'{op, z4,   e4});
        vecs.push_back(vec_t'{op, z5,   e5});
        vecs.push_back(vec_t'{op, 1'b0, e6});
        vecs.push_back(vec_t'{op, 1'b0, O_NONE});
        exp_inc.push_back(inc);
    endtask

    initial begin
        int inc_count;

        add_frame(LDA, 1'b0, 1'b0, O_RD,   O_RDACC, O_NONE, 2);
        add_frame(STO, 1'b0, 1'b0, O_DCTL, O_DCWR,  O_DCTL, 2);
        add_frame(SKZ, 1'b1, 1'b0, O_INC,  O_INC,   O_NONE, 4);
        add_frame(SKZ, 1'b0, 1'b1, O_NONE, O_NONE,  O_NONE, 2);
        add_frame(JMP, 1'b0, 1'b0, O_LDPC, O_LDPC,  O_NONE, 2);
        add_frame(ADD, 1'b0, 1'b0, O_RD,   O_RDACC, O_NONE, 2);
        add_frame(AND, 1'b1, 1'b1, O_RD,   O_RDACC, O_NONE, 2);
        add_frame(XOR, 1'b0, 1'b0, O_RD,   O_RDACC, O_NONE, 2);

        rst        = 1'b0;
        bus.ena    = 1'b1;
        bus.opcode = HLT;
        bus.zero   = 1'b0;

        applyStimulus(HLT, 1'b0);
        checkOutput("reset_cycle0", O_NONE);
        applyStimulus(HLT, 1'b0);
        checkOutput("reset_cycle1", O_NONE);

        rst       = 1'b1;
        inc_count = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].zero);
            checkOutput($sformatf("frame%0d_S%0d_op%0d", i / 8, i % 8, vecs[i].op), vecs[i].exp);
            inc_count += int'(bus.inc_pc);
            if (i % 8 == 7) begin
                n_checks++;
                if (inc_count != exp_inc[i / 8]) begin
                    n_fail++;
                    $display("[TB] FAIL inc_count_frame%0d: got %0d required %0d",
                             i / 8, inc_count, exp_inc[i / 8]);
                end
                inc_count = 0;
            end
        end

        // HLT frame, then halt must persist through idle and many cycles
        applyStimulus(HLT, 1'b0);
        checkOutput("hlt_S0", O_FETCH);
        applyStimulus(HLT, 1'b0);
        checkOutput("hlt_S1", O_FETCH);
        applyStimulus(HLT, 1'b0);
        checkOutput("hlt_S2", O_NONE);
        applyStimulus(HLT, 1'b0);
        checkOutput("hlt_S3", O_NONE);
        applyStimulus(ADD, 1'b0);
        checkOutput("hlt_enter", O_HALT);
        for (int i = 0; i < 100; i++) begin
            bus.ena = (i < 40 || i > 60);
            applyStimulus(JMP, i[0]);
        end
        checkOutput("hlt_after_100", O_HALT);
        rst = 1'b0;
        applyStimulus(HLT, 1'b0);
        checkOutput("hlt_cleared_by_reset", O_NONE);

        // ADD frame aborted by dropping ena before S5
        rst     = 1'b1;
        bus.ena = 1'b1;
        applyStimulus(ADD, 1'b0);
        checkOutput("abort_S0", O_FETCH);
        applyStimulus(ADD, 1'b0);
        checkOutput("abort_S1", O_FETCH);
        applyStimulus(ADD, 1'b0);
        checkOutput("abort_S2", O_NONE);
        applyStimulus(ADD, 1'b0);
        checkOutput("abort_S3", O_NONE);
        applyStimulus(ADD, 1'b0);
        checkOutput("abort_S4", O_RD);
        bus.ena = 1'b0;
        applyStimulus(ADD, 1'b0);
        checkOutput("abort_no_load_acc", O_NONE);
        applyStimulus(ADD, 1'b0);
        checkOutput("abort_idle", O_NONE);
        bus.ena = 1'b1;
        applyStimulus(ADD, 1'b0);
        checkOutput("abort_restart_S0", O_FETCH);
        applyStimulus(ADD, 1'b0);
        checkOutput("abort_restart_S1", O_FETCH);

        // STO frame interrupted by reset during S4: wr must never pulse
        rst = 1'b0;
        applyStimulus(STO, 1'b0);
        rst = 1'b1;
        applyStimulus(STO, 1'b0);
        checkOutput("sto_rst_S0", O_FETCH);
        applyStimulus(STO, 1'b0);
        applyStimulus(STO, 1'b0);
        applyStimulus(STO, 1'b0);
        checkOutput("sto_rst_S3", O_NONE);
        applyStimulus(STO, 1'b0);
        checkOutput("sto_rst_S4", O_DCTL);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(STO, 1'b0);
            checkOutput($sformatf("sto_rst_hold%0d", i), O_NONE);
        end
        rst = 1'b1;
        applyStimulus(STO, 1'b0);
        checkOutput("sto_rst_release_S0", O_FETCH);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
